video_sync_gen: RTL



---
 rtl/video_sync_gen_if.sv | 37 +++
 rtl/video_sync_gen.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/video_sync_gen_if.sv
// +---------------------------------------------------------------------------+
// | video_sync_gen_if : pixel-side bus of the 15 kHz raster generator. Rev 1.0 |
// +---------------------------------------------------------------------------+
`default_nettype none

interface video_sync_gen_if;
  logic       clk28en;
  logic       clk14en;
  logic [2:0] ri;
  logic [2:0] gi;
  logic [2:0] bi;
  logic [9:0] hcnt;
  logic [8:0] vcnt;
  logic       line_start;
  logic       frame_start;
  logic [2:0] ro;
  logic [2:0] go;
  logic [2:0] bo;
  logic       hsync_n;
  logic       vsync_n;
  logic       csync_n;
  logic       blank;

  modport master (
    input  clk28en, clk14en, ri, gi, bi,
    output hcnt, vcnt, line_start, frame_start,
    output ro, go, bo, hsync_n, vsync_n, csync_n, blank
  );

  modport slave (
    output clk28en, clk14en, ri, gi, bi,
    input  hcnt, vcnt, line_start, frame_start,
    input  ro, go, bo, hsync_n, vsync_n, csync_n, blank
  );
endinterface

`default_nettype wire

// File: rtl/video_sync_gen.sv
// +---------------------------------------------------------------------------+
// | video_sync_gen : 15 kHz raster timing, blanked RGB and syncs. Rev 1.0      |
// | Option macro VIDEO_SYNC_GEN_SERRATION_EN adds PAL serration to csync_n.    |
// +---------------------------------------------------------------------------+
`default_nettype none

module video_sync_gen #(
  parameter int H_TOTAL      = 896,
  parameter int H_ACTIVE     = 768,
  parameter int H_SYNC_START = 800,
  parameter int H_SYNC_W     = 64,
  parameter int V_TOTAL      = 320,
  parameter int V_ACTIVE     = 288,
  parameter int V_SYNC_START = 296,
  parameter int V_SYNC_LINES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  video_sync_gen_if.master vid
);

  localparam logic [9:0]  C_H_LAST = 10'(H_TOTAL - 1);
  localparam logic [8:0]  C_V_LAST = 9'(V_TOTAL - 1);
  localparam logic [10:0] C_H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] C_HS_BEG = 11'(H_SYNC_START);
  localparam logic [10:0] C_HS_END = 11'(H_SYNC_START + H_SYNC_W);
  localparam logic [9:0]  C_V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  C_VS_BEG = 10'(V_SYNC_START);
  localparam logic [9:0]  C_VS_END = 10'(V_SYNC_START + V_SYNC_LINES);

  if (H_TOTAL < 64 || H_TOTAL > 1024) begin : g_chk_htotal
    $error("video_sync_gen: H_TOTAL must be within 64..1024");
  end
  if (V_TOTAL < 1 || V_TOTAL > 512) begin : g_chk_vtotal
    $error("video_sync_gen: V_TOTAL must fit the 9-bit line counter");
  end
  if (H_SYNC_START + H_SYNC_W > H_TOTAL) begin : g_chk_hsync
    $error("video_sync_gen: hsync extends past H_TOTAL");
  end
  if (V_SYNC_START + V_SYNC_LINES > V_TOTAL) begin : g_chk_vsync
    $error("video_sync_gen: vsync extends past V_TOTAL");
  end
  if (H_ACTIVE > H_SYNC_START) begin : g_chk_hact
    $error("video_sync_gen: H_ACTIVE overlaps hsync");
  end
  if (V_ACTIVE > V_SYNC_START) begin : g_chk_vact
    $error("video_sync_gen: V_ACTIVE overlaps vsync");
  end

  logic [9:0]  hcnt_q, hcnt_d;
  logic [8:0]  vcnt_q, vcnt_d;
  logic [2:0]  ro_q, ro_d, go_q, go_d, bo_q, bo_d;
  logic        hs_q, hs_d, vs_q, vs_d, cs_q, cs_d;
  logic        blank_q, blank_d;

  logic        tick;
  logic        h_wrap;
  logic [10:0] h_ext;
  logic [9:0]  v_ext;
  logic        blank_p;
  logic        hs_low;
  logic        vs_low;
  logic        cs_low;

  assign tick    = vid.clk28en & vid.clk14en;
  assign h_wrap  = (hcnt_q == C_H_LAST);
  assign h_ext   = {1'b0, hcnt_q};
  assign v_ext   = {1'b0, vcnt_q};
  assign blank_p = (h_ext >= C_H_ACT) || (v_ext >= C_V_ACT);
  assign hs_low  = (h_ext >= C_HS_BEG) && (h_ext < C_HS_END);
  assign vs_low  = (v_ext >= C_VS_BEG) && (v_ext < C_VS_END);

`ifdef VIDEO_SYNC_GEN_SERRATION_EN
  localparam logic [9:0] C_HALF   = 10'(H_TOTAL / 2);
  localparam logic [9:0] C_SER_HI = 10'(H_TOTAL / 2 - H_SYNC_W);

  if (H_SYNC_W > H_TOTAL / 2) begin : g_chk_serr
    $error("video_sync_gen: H_SYNC_W must fit inside a half-line");
  end

  // Position inside the current half-line; each half ends with an H_SYNC_W high pulse.
  logic [9:0] hpos;
  assign hpos   = (hcnt_q >= C_HALF) ? (hcnt_q - C_HALF) : hcnt_q;
  assign cs_low = vs_low ? (hpos < C_SER_HI) : hs_low;
`else
  assign cs_low = hs_low | vs_low;
`endif

  always_comb begin
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    ro_d    = ro_q;
    go_d    = go_q;
    bo_d    = bo_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    cs_d    = cs_q;
    blank_d = blank_q;
    if (tick) begin
      hcnt_d = h_wrap ? 10'd0 : hcnt_q + 10'd1;
      if (h_wrap) begin
        vcnt_d = (vcnt_q == C_V_LAST) ? 9'd0 : vcnt_q + 9'd1;
      end
      ro_d    = blank_p ? 3'd0 : vid.ri;
      go_d    = blank_p ? 3'd0 : vid.gi;
      bo_d    = blank_p ? 3'd0 : vid.bi;
      hs_d    = ~hs_low;
      vs_d    = ~vs_low;
      cs_d    = ~cs_low;
      blank_d = blank_p;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q  <= 10'd0;
      vcnt_q  <= 9'd0;
      ro_q    <= 3'd0;
      go_q    <= 3'd0;
      bo_q    <= 3'd0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      cs_q    <= 1'b1;
      blank_q <= 1'b1;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      ro_q    <= ro_d;
      go_q    <= go_d;
      bo_q    <= bo_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      cs_q    <= cs_d;
      blank_q <= blank_d;
    end
  end

  // Position strobes follow the counters directly but stay low while reset is held.
  assign vid.line_start  = rst_n & (hcnt_q == 10'd0);
  assign vid.frame_start = rst_n & (hcnt_q == 10'd0) & (vcnt_q == 9'd0);
  assign vid.hcnt        = hcnt_q;
  assign vid.vcnt        = vcnt_q;
  assign vid.ro          = ro_q;
  assign vid.go          = go_q;
  assign vid.bo          = bo_q;
  assign vid.hsync_n     = hs_q;
  assign vid.vsync_n     = vs_q;
  assign vid.csync_n     = cs_q;
  assign vid.blank       = blank_q;

endmodule

`default_nettype wire
